// File: rtl/i2c_mpu_responder.sv
// I2C target emulating the MPU-6050 register interface: START/STOP detection,
// 7-bit address match, pointer/register writes and auto-incrementing burst
// reads from a 14-byte sensor shadow that is kept coherent across a burst.
//
// Bus handshake: the only flow control is the I2C ACK bit. A byte is accepted
// when its 8th SCL rise is seen; the responder answers by pulling SDA low for
// the 9th clock. reg_wr_valid is a one-cycle strobe with no ready.
`timescale 1ns/1ps
module i2c_mpu_responder #(
  parameter logic [6:0] DEV_ADDR     = 7'h68,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
  parameter logic [7:0] PWR_RST_VAL  = 8'h40,
  parameter int         HOLD_CYC     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         scl_in,
  input  logic         sda_in,
  output logic         sda_oe,
  output logic         sda_out,
  input  logic         sample_load,
  input  logic [111:0] sample_data,
  output logic         reg_wr_valid,
  output logic [7:0]   reg_wr_addr,
  output logic [7:0]   reg_wr_data,
  output logic         busy,
  output logic [7:0]   pwr_mgmt
);

  localparam int HW = $clog2(HOLD_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_REG_ADDR, S_REG_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
  } state_t;

  // Kept as a named register so checkers can bind to it.
  state_t         state;
  logic           scl_s1, scl_s2, scl_d;
  logic           sda_s1, sda_s2, sda_d;
  logic           scl_rise, scl_fall, start_evt, stop_evt;
  logic [2:0]     bit_cnt;
  logic [7:0]     rx_sh, rx_byte, tx_sh, ptr;
  logic           rw, ptr_written, drive;
  logic [HW-1:0]  hold_cnt;
  logic [111:0]   shadow, pending;
  logic           pend_valid;

  assign sda_out = 1'b0;

  // Read-side register map.
  function automatic logic [7:0] rd_byte(input logic [7:0] p,
                                         input logic [111:0] sh,
                                         input logic [7:0] pm);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 14; i++)
      if (p == 8'h3B + 8'(i)) v = sh[8*(13-i) +: 8];
    if (p == 8'h6B) v = pm;
    if (p == 8'h75) v = WHO_AM_I_VAL;
    return v;
  endfunction

  // Two-flop synchronizers plus one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      {scl_s1, scl_s2, scl_d} <= 3'b111;
      {sda_s1, sda_s2, sda_d} <= 3'b111;
    end else begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_evt = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_evt  = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign rx_byte   = {rx_sh[6:0], sda_s2};

  // SDA level wanted for the current bit slot, applied HOLD_CYC after SCL falls.
  always_comb begin
    drive = 1'b0;
    case (state)
      S_DEV_ACK, S_REG_ACK, S_WR_ACK: drive = 1'b1;
      S_RD_DATA:                      drive = ~tx_sh[7];
      default:                        drive = 1'b0;
    endcase
  end

  // Protocol FSM, register file and shadow management.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      sda_oe       <= 1'b0;
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= 8'h00;
      reg_wr_data  <= 8'h00;
      busy         <= 1'b0;
      pwr_mgmt     <= PWR_RST_VAL;
      ptr          <= 8'h00;
      ptr_written  <= 1'b0;
      bit_cnt      <= 3'd0;
      rx_sh        <= 8'h00;
      tx_sh        <= 8'h00;
      rw           <= 1'b0;
      hold_cnt     <= '0;
      shadow       <= '0;
      pending      <= '0;
      pend_valid   <= 1'b0;
    end else begin
      reg_wr_valid <= 1'b0;
      if (start_evt) begin
        state    <= S_DEV_ADDR;
        bit_cnt  <= 3'd0;
        sda_oe   <= 1'b0;
        hold_cnt <= '0;
      end else if (stop_evt) begin
        state       <= S_IDLE;
        sda_oe      <= 1'b0;
        busy        <= 1'b0;
        hold_cnt    <= '0;
        ptr_written <= 1'b0;
      end else begin
        if (scl_fall) begin
          hold_cnt <= HW'(HOLD_CYC);
        end else if (hold_cnt != '0) begin
          hold_cnt <= hold_cnt - HW'(1);
          if (hold_cnt == HW'(1)) sda_oe <= drive;
        end
        if (scl_rise) begin
          rx_sh <= rx_byte;
          case (state)
            S_DEV_ADDR: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state <= S_DEV_ACK;
                  busy  <= 1'b1;
                  rw    <= rx_byte[0];
                end else begin
                  state <= S_IDLE;
                end
              end
            end
            S_DEV_ACK: begin
              if (rw) begin
                state <= S_RD_DATA;
                tx_sh <= rd_byte(ptr, shadow, pwr_mgmt);
              end else if (ptr_written) begin
                state <= S_WR_DATA;
              end else begin
                state <= S_REG_ADDR;
              end
            end
            S_REG_ADDR: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ptr         <= rx_byte;
                ptr_written <= 1'b1;
                state       <= S_REG_ACK;
              end
            end
            S_REG_ACK: state <= S_WR_DATA;
            S_WR_DATA: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                reg_wr_valid <= 1'b1;
                reg_wr_addr  <= ptr;
                reg_wr_data  <= rx_byte;
                if (ptr == 8'h6B) pwr_mgmt <= rx_byte;
                ptr   <= ptr + 8'd1;
                state <= S_WR_ACK;
              end
            end
            S_WR_ACK: state <= S_WR_DATA;
            S_RD_DATA: begin
              tx_sh   <= {tx_sh[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= S_RD_ACK;
            end
            S_RD_ACK: begin
              if (!sda_s2) begin
                ptr   <= ptr + 8'd1;
                tx_sh <= rd_byte(ptr + 8'd1, shadow, pwr_mgmt);
                state <= S_RD_DATA;
              end else begin
                state <= S_WAIT_STOP;
              end
            end
            default: ;
          endcase
        end
      end
      // A snapshot deferred during a transaction lands once busy has dropped;
      // a fresh strobe in that same cycle is newer and overrides it.
      if (!busy && pend_valid) begin
        shadow     <= pending;
        pend_valid <= 1'b0;
      end
      if (sample_load) begin
        if (busy) begin
          pending    <= sample_data;
          pend_valid <= 1'b1;
        end else begin
          shadow <= sample_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_mpu_responder.sv
// Bench for i2c_mpu_responder: bit-level I2C master tasks, a transaction-level
// register model, and a scoreboard for register-write strobes.
`timescale 1ns/1ps
module tb_i2c_mpu_responder;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic         scl = 1'b1, sda_m = 1'b1;
  wire          sda_in;
  logic         sda_oe, sda_out, reg_wr_valid, busy;
  logic [7:0]   reg_wr_addr, reg_wr_data, pwr_mgmt;
  logic         sample_load = 1'b0;
  logic [111:0] sample_data = '0;

  assign sda_in = sda_m & ~sda_oe;

  i2c_mpu_responder dut (
    .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_in),
    .sda_oe(sda_oe), .sda_out(sda_out),
    .sample_load(sample_load), .sample_data(sample_data),
    .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .busy(busy), .pwr_mgmt(pwr_mgmt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_shadow [14];
  logic [7:0] m_pend   [14];
  bit         m_pend_v;
  bit         m_busy;
  logic [7:0] m_ptr, m_pwr;

  function automatic logic [7:0] m_read(input logic [7:0] p);
    int idx;
    idx = int'(p) - 'h3B;
    if (idx >= 0 && idx < 14) return m_shadow[idx];
    if (p == 8'h6B) return m_pwr;
    if (p == 8'h75) return 8'h68;
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 14; i++) begin m_shadow[i] = 8'h00; m_pend[i] = 8'h00; end
    m_pend_v = 0; m_busy = 0; m_ptr = 8'h00; m_pwr = 8'h40;
  endtask

  task automatic model_stop();
    m_busy = 0;
    if (m_pend_v) begin
      for (int i = 0; i < 14; i++) m_shadow[i] = m_pend[i];
      m_pend_v = 0;
    end
  endtask

  // ---------------- scoreboard for write strobes ----------------
  logic [15:0] exp_q[$];
  int          extra_wr = 0;
  bit          oe_seen  = 0;

  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1;
    if (reg_wr_valid) begin
      if (exp_q.size() != 0) check("wr_pulse", {reg_wr_addr, reg_wr_data}, exp_q.pop_front());
      else extra_wr++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_bit(input bit b, output bit s);
    wait_q(); sda_m = b;
    wait_q(); scl = 1'b1;
    wait_q(); s = sda_in;
    wait_q(); scl = 1'b0;
  endtask

  task automatic m_start();
    wait_q(); sda_m = 1'b1;
    wait_q(); scl = 1'b1;
    wait_q(); sda_m = 1'b0;
    wait_q(); scl = 1'b0;
  endtask

  task automatic m_stop();
    wait_q(); sda_m = 1'b0;
    wait_q(); scl = 1'b1;
    wait_q(); sda_m = 1'b1;
    wait_q();
    model_stop();
  endtask

  task automatic m_write_byte(input logic [7:0] b, output bit ack);
    bit s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic m_read_byte(input bit nack, output logic [7:0] d);
    bit s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin bus_bit(1'b1, s); d = {d[6:0], s}; end
    bus_bit(nack, s);
  endtask

  task automatic do_sample_load(input logic [111:0] d);
    @(negedge clk); sample_load = 1'b1; sample_data = d;
    @(negedge clk); sample_load = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (m_busy) m_pend[i] = d[8*(13-i) +: 8];
      else        m_shadow[i] = d[8*(13-i) +: 8];
    end
    if (m_busy) m_pend_v = 1;
  endtask

  // Write n bytes starting at register r; first byte d0, rest random.
  task automatic tx_write(input logic [7:0] r, input int n, input logic [7:0] d0);
    bit ack;
    logic [7:0] d;
    m_start();
    m_write_byte(8'hD0, ack); check("wr_addr_ack", ack, 1'b1);
    m_busy = 1;
    m_write_byte(r, ack); check("wr_reg_ack", ack, 1'b1);
    m_ptr = r;
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? d0 : 8'($urandom_range(0, 255));
      exp_q.push_back({m_ptr, d});
      if (m_ptr == 8'h6B) m_pwr = d;
      m_ptr = m_ptr + 8'd1;
      m_write_byte(d, ack); check("wr_data_ack", ack, 1'b1);
    end
    m_stop();
    check("busy_after_stop", busy, 1'b0);
    check("pwr_mgmt", pwr_mgmt, m_pwr);
  endtask

  // Burst read of n bytes; optionally sets the pointer first via repeated START.
  logic [111:0] last_pack;
  task automatic tx_read(input logic [7:0] r, input int n, input bit set_ptr,
                         input int load_after, input logic [111:0] load_val);
    bit ack;
    logic [7:0] d;
    m_start();
    if (set_ptr) begin
      m_write_byte(8'hD0, ack); check("rd_waddr_ack", ack, 1'b1);
      m_busy = 1;
      m_write_byte(r, ack); check("rd_reg_ack", ack, 1'b1);
      m_ptr = r;
      m_start();
    end
    m_write_byte(8'hD1, ack); check("rd_addr_ack", ack, 1'b1);
    m_busy = 1;
    check("busy_in_read", busy, 1'b1);
    last_pack = '0;
    for (int i = 0; i < n; i++) begin
      m_read_byte(i == n - 1, d);
      check("rd_byte", d, m_read(m_ptr));
      last_pack = {last_pack[103:0], d};
      if (i != n - 1) m_ptr = m_ptr + 8'd1;
      if (i == load_after) do_sample_load(load_val);
    end
    m_stop();
    check("busy_after_stop", busy, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #4ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  logic [127:0] rnd;
  logic [111:0] ramp;
  bit           ack;

  initial begin
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_sda_out", sda_out, 1'b0);
    check("rst_wr_valid", reg_wr_valid, 1'b0);
    check("rst_wr_addr", reg_wr_addr, 8'h00);
    check("rst_wr_data", reg_wr_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_pwr", pwr_mgmt, 8'h40);

    // Wake the device.
    tx_write(8'h6B, 1, 8'h00);

    // Ramp snapshot, full 14-byte burst.
    for (int i = 0; i < 14; i++) ramp[8*(13-i) +: 8] = 8'(i + 1);
    do_sample_load(ramp);
    tx_read(8'h3B, 14, 1, -1, '0);
    check("burst_pack", last_pack, 112'h0102030405060708090A0B0C0D0E);

    // Foreign address must never be acknowledged or driven.
    oe_seen = 0;
    m_start();
    m_write_byte(8'hD2, ack);
    check("foreign_ack", ack, 1'b0);
    check("foreign_busy", busy, 1'b0);
    m_stop();
    check("foreign_oe", oe_seen, 1'b0);

    // WHO_AM_I and an unmapped register.
    tx_read(8'h75, 1, 1, -1, '0);
    tx_read(8'h6A, 1, 1, -1, '0);

    // Snapshot update during a burst is deferred until STOP.
    tx_read(8'h3B, 14, 1, 2, {112{1'b1}});
    tx_read(8'h3B, 1, 1, -1, '0);

    // Reset while the ACK is being driven.
    m_start();
    for (int i = 7; i >= 0; i--) begin
      bit s;
      bus_bit(((8'hD0 >> i) & 8'h01) != 0, s);
    end
    wait_q(); sda_m = 1'b1;
    wait_q();
    check("ack_driven", sda_oe, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_oe", sda_oe, 1'b0);
    rst = 1'b0;
    model_reset();
    wait_q(); scl = 1'b1;
    wait_q();
    tx_write(8'h6B, 1, 8'h01);
    tx_read(8'hFF, 2, 1, -1, '0);

    // Randomized traffic.
    repeat (14) begin
      case ($urandom_range(0, 3))
        0: begin
          rnd = {$urandom, $urandom, $urandom, $urandom};
          do_sample_load(rnd[111:0]);
        end
        1: begin
          case ($urandom_range(0, 2))
            0:       tx_write(8'h6A, $urandom_range(1, 3), 8'($urandom_range(0, 255)));
            1:       tx_write(8'(8'h3B + $urandom_range(0, 13)), $urandom_range(1, 3), 8'($urandom_range(0, 255)));
            default: tx_write(8'($urandom_range(0, 255)), $urandom_range(1, 3), 8'($urandom_range(0, 255)));
          endcase
        end
        2: begin
          rnd = {$urandom, $urandom, $urandom, $urandom};
          tx_read(8'(8'h3A + $urandom_range(0, 14)), $urandom_range(1, 6), 1,
                  $urandom_range(0, 4), rnd[111:0]);
        end
        default: tx_read(8'h00, $urandom_range(1, 4), 0, -1, '0);
      endcase
    end

    repeat (10) @(negedge clk);
    check("wr_queue_empty", 32'(exp_q.size()), 32'd0);
    check("wr_extra", 32'(extra_wr), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_mpu_responder.md
Name: i2c_mpu_responder

Overview:
Synthesizable I2C target that emulates the MPU-6050 register interface seen by the `mpu` I2C master. It samples the open-drain bus, detects START, repeated START and STOP, and matches its 7-bit device address. It accepts register-pointer and register writes, and serves auto-incrementing burst reads from a 14-byte sensor shadow. It is used as the bus-side model in `mpu` benches and on the FPGA loopback board.

Parameters:
DEV_ADDR, 7'h68, 7-bit device address (write byte 0xD0, read byte 0xD1)
WHO_AM_I_VAL, 8'h68, value returned at register 0x75
PWR_RST_VAL, 8'h40, reset value of register 0x6B (PWR_MGMT_1)
HOLD_CYC, 4, clk cycles after a detected SCL fall before sda_oe may change (must be >=1)

Ports:
clk  in  1  system clock, 50 MHz, at least 16x SCL
rst  in  1  synchronous active-high reset
scl_in  in  1  bus SCL level, asynchronous
sda_in  in  1  bus SDA level, asynchronous
sda_oe  out  1  1 = pull SDA low; 0 = release SDA
sda_out  out  1  constant 0; open-drain data value
sample_load  in  1  one-cycle strobe that captures sample_data
sample_data  in  112  14 bytes; [111:104] maps to reg 0x3B, [7:0] maps to reg 0x48
reg_wr_valid  out  1  one-cycle pulse per accepted data byte written
reg_wr_addr  out  8  register address of that write
reg_wr_data  out  8  data byte of that write
busy  out  1  high from address-matched START until STOP
pwr_mgmt  out  8  current contents of register 0x6B

Behaviour:
- Input sampling: scl_in and sda_in each pass through a 2-flop synchronizer, then a third flop for edge detection. Bus events are acted on 3 clk after the pin changes.
- START: synchronized SDA falls while SCL is high. Recognized in any state, which also covers repeated START. Bit counter clears, sda_oe=0, next state DEV_ADDR.
- STOP: synchronized SDA rises while SCL is high. Recognized in any state. Next state IDLE, sda_oe=0, busy=0, then the deferred shadow load is applied.
- Data sampling: on SCL rise, MSB first. After a detected SCL fall, the responder waits HOLD_CYC clk before updating sda_oe.
- States:
  - IDLE → DEV_ADDR on START.
  - DEV_ADDR: after 8 bits, if [7:1]==DEV_ADDR, go to DEV_ACK and set busy=1. On mismatch go to IDLE without ACK; SDA is not driven until the next START.
  - DEV_ACK: drive ACK (sda_oe=1) for the 9th clock.
    - R/W=0 with no pointer yet written in this transaction → REG_ADDR.
    - R/W=0 after the pointer was written → WR_DATA.
    - R/W=1 → RD_DATA, with the first byte loaded from the pointer.
  - REG_ADDR: 8 bits → REG_ACK (ACK). The pointer is set to the received byte. Next state WR_DATA.
  - WR_DATA: 8 bits → WR_ACK (always ACK). In the same cycle as the 8th SCL rise: reg_wr_valid=1, reg_wr_addr=pointer, reg_wr_data=byte. If pointer==0x6B, pwr_mgmt is updated. The pointer increments. Next state WR_DATA.
  - RD_DATA: shift out 8 bits. sda_oe = ~bit, so a 1 releases the line. Next state RD_ACK.
  - RD_ACK: release SDA and sample the master bit on SCL rise. ACK (0): pointer increments, next byte is loaded, next state RD_DATA. NACK (1): next state IDLE-wait, with SDA released until STOP or START.
- Register map:
  - 0x3B–0x48 read the shadow bytes.
  - 0x6B reads/writes pwr_mgmt.
  - 0x75 reads WHO_AM_I_VAL.
  - All other addresses read 0x00; writes to them are ACKed and pulse reg_wr_valid but store nothing.
- Pointer: 8-bit, wraps 0xFF→0x00. It persists across transactions, so a write-pointer then repeated-START read works.
- Shadow coherency: sample_load while busy=0 updates the shadow on the next clk. While busy=1, sample_data is captured into a pending register, and a pending flag is set, last strobe wins. The pending data is copied into the shadow in the clk after STOP. This keeps a burst coherent.
- Simultaneous events: a START or STOP edge takes priority over data sampling in the same clk.
- Reset values: sda_oe=0, sda_out=0, reg_wr_valid=0, reg_wr_addr=0, reg_wr_data=0, busy=0, pwr_mgmt=PWR_RST_VAL, pointer=0, shadow=0, pending flag=0, state=IDLE.
- Reset mid-transaction: sda_oe returns to 0 on the first clk with rst=1. The responder then ignores the bus until a fresh START.

Test Plan:
- Write 0xD0, 0x6B, 0x00, STOP → ACK on all 3 bytes; one reg_wr_valid pulse with addr 0x6B, data 0x00; pwr_mgmt=0x00; busy low after STOP.
- sample_load with 0x0102…0E (14 bytes). Then write 0xD0, 0x3B, repeated START, 0xD1, read 14 bytes (ACK ×13, NACK last) → bytes 0x01..0x0E in order; the 112-bit pack as assembled by `mpu` = 0x0102030405060708090A0B0C0D0E.
- Address 0xD2 (7'h69) → SDA never driven low (9th bit reads 1); busy stays 0; no reg_wr_valid.
- Pointer 0x75, repeated START, read 1 byte with NACK → 0x68. Then read at 0x6A → 0x00.
- Mid-burst sample_load of all-0xFF after byte 3 → remaining bytes still come from the old snapshot. After STOP, a new read from 0x3B returns 0xFF.
- Assert rst while the responder drives ACK → sda_oe=0 next clk. A following clean write 0xD0/0x6B/0x01 is ACKed; pwr_mgmt=0x01. Pointer 0xFF with a 2-byte read → second byte from 0x00, reading 0x00.
